// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs instruction requests (opcode plus operand fields) into 16-bit
// instruction words and writes them to consecutive instruction-memory
// addresses. This is the encoding side of the opcode/func format that the
// Controller decodes. The test harness and the boot path use it to load
// programs before the core starts running.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle pulse that opens a load session at base_addr
//   base_addr    first word address of the session
//   req_valid    instruction request valid
//   req_ready    loader accepts a request this cycle (LOAD state only)
//   req_last     marks the final request of the session
//   req_opcode   opcode to encode
//   req_func     ALU func field (opcode 1000 only)
//   req_ri       first register field
//   req_rj       second register field (opcode 1000 only)
//   req_imm      immediate/address/offset field
//   imem_we      instruction-memory write strobe
//   imem_addr    write address
//   imem_wdata   encoded instruction word
//   busy         a session is in progress
//   done         one-cycle pulse at session end
//   err_illegal  sticky, an unsupported opcode was rejected
//   err_range    sticky, an immediate did not fit its field
//   err_ovf      sticky, the end of memory was reached before req_last
//   wr_count     words written in the current session
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [3:0]        req_opcode,
    input  logic [7:0]        req_func,
    input  logic [1:0]        req_ri,
    input  logic [1:0]        req_rj,
    input  logic [11:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_range,
    output logic              err_ovf,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t             state_reg;
    state_t             state_next;

    logic [ADDR_W-1:0]  addr_reg;       // address the next accepted word goes to
    logic               we_reg;
    logic [ADDR_W-1:0]  waddr_reg;
    logic [15:0]        wdata_reg;
    logic [ADDR_W:0]    wr_count_reg;
    logic               err_illegal_reg;
    logic               err_range_reg;
    logic               err_ovf_reg;

    logic               op_legal;
    logic               imm_ok;
    logic [15:0]        enc_word;
    logic               hs;
    logic               accept;
    logic               ovf_hit;

    // ---------------------------------------------------------------------
    // Instruction encoding and field checks
    // ---------------------------------------------------------------------
    always_comb begin
        op_legal = 1'b1;
        imm_ok   = (req_imm[11:10] == 2'b00);
        enc_word = '0;
        case (req_opcode)
            4'b0000, 4'b0001, 4'b0100,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                enc_word = {req_opcode, req_ri, req_imm[9:0]};
            end
            4'b0010: begin
                // Jump uses the full 12-bit field, so nothing can be out of range.
                enc_word = {req_opcode, req_imm};
                imm_ok   = 1'b1;
            end
            4'b1000: begin
                // ALU format carries no immediate.
                enc_word = {req_opcode, req_ri, req_rj, req_func};
                imm_ok   = 1'b1;
            end
            default: begin
                op_legal = 1'b0;
            end
        endcase
    end

    assign hs     = req_valid & req_ready;
    assign accept = hs & op_legal & imm_ok;
    // A word landing on the last address with more requests still to come
    // ends the session early; addr never wraps.
    assign ovf_hit = accept & ~req_last & (addr_reg == ADDR_MAX);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  if (hs && (req_last || ovf_hit)) state_next = S_FLUSH;
            // The word accepted on the closing handshake is written during
            // this single FLUSH cycle.
            S_FLUSH: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        req_ready = (state_reg == S_LOAD);
        busy      = (state_reg != S_IDLE);
        done      = (state_reg == S_DONE);
    end

    // ---------------------------------------------------------------------
    // Datapath: write pipeline register, address, counters, sticky errors
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg        <= '0;
            we_reg          <= 1'b0;
            waddr_reg       <= '0;
            wdata_reg       <= '0;
            wr_count_reg    <= '0;
            err_illegal_reg <= 1'b0;
            err_range_reg   <= 1'b0;
            err_ovf_reg     <= 1'b0;
        end else begin
            we_reg <= accept;

            // The address advances at acceptance so that a handshake in the
            // same cycle as the previous write already targets addr+1.
            if (accept) begin
                waddr_reg <= addr_reg;
                wdata_reg <= enc_word;
                if (addr_reg != ADDR_MAX) begin
                    addr_reg <= addr_reg + 1'b1;
                end
            end

            if (we_reg) begin
                wr_count_reg <= wr_count_reg + 1'b1;
            end

            if (hs && !op_legal) begin
                err_illegal_reg <= 1'b1;
            end
            if (hs && op_legal && !imm_ok) begin
                err_range_reg <= 1'b1;
            end
            if (ovf_hit) begin
                err_ovf_reg <= 1'b1;
            end

            // No write can be in flight while IDLE, so session setup simply
            // overrides everything above.
            if (state_reg == S_IDLE && start) begin
                addr_reg        <= base_addr;
                wr_count_reg    <= '0;
                err_illegal_reg <= 1'b0;
                err_range_reg   <= 1'b0;
                err_ovf_reg     <= 1'b0;
            end
        end
    end

    assign imem_we     = we_reg;
    assign imem_addr   = waddr_reg;
    assign imem_wdata  = wdata_reg;
    assign wr_count    = wr_count_reg;
    assign err_illegal = err_illegal_reg;
    assign err_range   = err_range_reg;
    assign err_ovf     = err_ovf_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              req_valid;
    logic              req_ready;
    logic              req_last;
    logic [3:0]        req_opcode;
    logic [7:0]        req_func;
    logic [1:0]        req_ri;
    logic [1:0]        req_rj;
    logic [11:0]       req_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_range;
    logic              err_ovf;
    logic [ADDR_W:0]   wr_count;

    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_opcode(req_opcode), .req_func(req_func), .req_ri(req_ri),
        .req_rj(req_rj), .req_imm(req_imm), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .err_illegal(err_illegal), .err_range(err_range),
        .err_ovf(err_ovf), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  func;
        logic [1:0]  ri;
        logic [1:0]  rj;
        logic [11:0] imm;
        logic        last;
        logic        st;     // also pulse start while this request is offered
    } req_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    req_t reqs_q[$];
    wr_t  exp_q[$];
    wr_t  wr_q[$];
    int   exp_ill, exp_rng, exp_ovf, n_acc;
    int   done_cnt, cur_run, max_run;
    int   errors = 0;
    int   checks = 0;

    // ---------------- observation ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                wr_q.push_back('{int'(imem_addr), int'(imem_wdata)});
                cur_run = cur_run + 1;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (done) done_cnt = done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Walks the request list the way a programmer would read the loader's
    // rules: count addresses, encode legal words, stop at last/overflow.
    task automatic model(input int base);
        int a;
        int op, imm, enc;
        bit legal, fits;
        exp_q.delete();
        exp_ill = 0; exp_rng = 0; exp_ovf = 0; n_acc = 0;
        a = base;
        foreach (reqs_q[i]) begin
            op  = reqs_q[i].op;
            imm = reqs_q[i].imm;
            n_acc++;
            legal = (op inside {0, 1, 2, 4, 8, 12, 13, 14, 15});
            fits  = (op == 2) || (op == 8) || (imm < 1024);
            if (!legal) exp_ill = 1;
            else if (!fits) exp_rng = 1;
            else begin
                if (op == 2)      enc = op * 4096 + imm;
                else if (op == 8) enc = op * 4096 + reqs_q[i].ri * 1024 + reqs_q[i].rj * 256 + reqs_q[i].func;
                else              enc = op * 4096 + reqs_q[i].ri * 1024 + (imm % 1024);
                exp_q.push_back('{a, enc});
                if (a == (1 << ADDR_W) - 1 && !reqs_q[i].last) begin
                    exp_ovf = 1;
                    break;
                end
                a++;
            end
            if (reqs_q[i].last) break;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        start = 0; req_valid = 0; req_last = 0; req_opcode = 0;
        req_func = 0; req_ri = 0; req_rj = 0; req_imm = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, req_ready, 0);
        chk({tag, ".imem_we"}, imem_we, 0);
        chk({tag, ".imem_addr"}, imem_addr, 0);
        chk({tag, ".imem_wdata"}, imem_wdata, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".errs"}, {err_illegal, err_range, err_ovf}, 0);
        chk({tag, ".wr_count"}, wr_count, 0);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send_one(input req_t r, input string tag);
        int w;
        req_valid = 1; req_opcode = r.op; req_func = r.func; req_ri = r.ri;
        req_rj = r.rj; req_imm = r.imm; req_last = r.last; start = r.st;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (w >= 10) chk({tag, ".ready_timeout"}, 0, 1);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic open_session(input int base);
        wr_q.delete();
        done_cnt = 0; cur_run = 0; max_run = 0;
        @(negedge clk);
        start = 1; base_addr = base[ADDR_W-1:0];
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_session(input int base, input int gap_max, input string tag);
        int w;
        model(base);
        open_session(base);
        for (int i = 0; i < n_acc; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            send_one(reqs_q[i], tag);
        end
        chk({tag, ".ready_after_close"}, req_ready, 0);
        w = 0;
        while (done_cnt == 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".done_seen"}, (done_cnt != 0), 1);
        @(negedge clk);
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".n_writes"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk($sformatf("%s.addr[%0d]", tag, i), wr_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s.data[%0d]", tag, i), wr_q[i].data, exp_q[i].data);
        end
        chk({tag, ".wr_count"}, wr_count, exp_q.size());
        chk({tag, ".errs"}, {err_illegal, err_range, err_ovf}, {exp_ill[0], exp_rng[0], exp_ovf[0]});
        $display("session %s base=0x%0h reqs=%0d writes=%0d ill=%0d rng=%0d ovf=%0d",
                 tag, base, n_acc, wr_q.size(), err_illegal, err_range, err_ovf);
    endtask

    function automatic req_t mk(input int op, input int func, input int ri, input int rj,
                                input int imm, input bit last);
        req_t r;
        r.op = op[3:0]; r.func = func[7:0]; r.ri = ri[1:0]; r.rj = rj[1:0];
        r.imm = imm[11:0]; r.last = last; r.st = 0;
        return r;
    endfunction

    initial begin
        req_t r;
        int n, base;
        idle_inputs();
        base_addr = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;

        // 1: two-word program
        reqs_q.delete();
        reqs_q.push_back(mk(12, 0, 1, 0, 5, 0));
        reqs_q.push_back(mk(8, 8'h84, 2, 3, 0, 1));
        run_session(16'h10, 0, "t1");
        if (wr_q.size() == 2) begin
            chk("t1.word0", {wr_q[0].addr[7:0], wr_q[0].data[15:0]}, 24'h10C405);
            chk("t1.word1", {wr_q[1].addr[7:0], wr_q[1].data[15:0]}, 24'h118B84);
        end else chk("t1.count", wr_q.size(), 2);

        // 2: jump with full 12-bit immediate
        reqs_q.delete();
        reqs_q.push_back(mk(2, 0, 0, 0, 12'hABC, 1));
        run_session(16'h40, 0, "t2");
        chk("t2.word", (wr_q.size() > 0) ? wr_q[0].data : -1, 16'h2ABC);
        chk("t2.err_range", err_range, 0);

        // 3: illegal opcode rejected, following word lands at base
        reqs_q.delete();
        reqs_q.push_back(mk(3, 0, 1, 0, 5, 0));
        reqs_q.push_back(mk(1, 0, 1, 0, 12'h3FF, 1));
        run_session(16'h30, 1, "t3");
        chk("t3.word", (wr_q.size() > 0) ? {wr_q[0].addr[7:0], wr_q[0].data[15:0]} : -1, 24'h3017FF);
        chk("t3.err_illegal", err_illegal, 1);

        // 4: overflow at end of memory
        reqs_q.delete();
        for (int i = 0; i < 3; i++) reqs_q.push_back(mk(14, 0, i, 0, i + 1, 0));
        run_session(16'hFE, 0, "t4");
        chk("t4.err_ovf", err_ovf, 1);
        chk("t4.n_acc", n_acc, 2);

        // 5: out-of-range immediate, then reset with a write in flight
        open_session(16'h20);
        send_one(mk(13, 0, 0, 0, 12'h400, 0), "t5");
        send_one(mk(12, 0, 1, 0, 1, 0), "t5");
        chk("t5.err_range", err_range, 1);
        chk("t5.we_pending", imem_we, 1);
        chk("t5.wdata_pending", imem_wdata, 16'hC401);
        rst = 1;
        #1;
        check_reset_outputs("t5.rst");
        @(negedge clk);
        rst = 0;
        $display("session t5 reset mid-session");

        // 6: eight back-to-back requests with an ignored start in LOAD
        reqs_q.delete();
        for (int i = 0; i < 8; i++) reqs_q.push_back(mk(4, 0, i, 0, 16 * i + 3, i == 7));
        reqs_q[3].st = 1;
        run_session(16'h80, 0, "t6");
        chk("t6.max_run", max_run, 8);

        // randomized sessions
        for (int s = 0; s < 30; s++) begin
            reqs_q.delete();
            n = $urandom_range(10, 1);
            base = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 248) : $urandom_range(255, 0);
            for (int i = 0; i < n; i++) begin
                r.op   = $urandom_range(15, 0);
                r.func = $urandom_range(255, 0);
                r.ri   = $urandom_range(3, 0);
                r.rj   = $urandom_range(3, 0);
                r.imm  = ($urandom_range(3, 0) == 0) ? 12'($urandom_range(4095, 0))
                                                     : 12'($urandom_range(1023, 0));
                r.last = (i == n - 1);
                r.st   = ($urandom_range(7, 0) == 0);
                reqs_q.push_back(r);
            end
            run_session(base, 2, $sformatf("rnd%0d", s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
